// File: rtl/p2s_addr_data_tx_if.sv
// Request and serial-line bundle for p2s_addr_data_tx. The transmitter owns the
// serial lines (master); the frame requester drives start/address/data_in (slave).
interface p2s_addr_data_tx_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  ready;
  logic                  tx_address;
  logic                  tx_addr_valid;
  logic                  tx_data;
  logic                  tx_data_valid;
  logic                  done;

  modport master (
    input  start, address, data_in,
    output ready, tx_address, tx_addr_valid, tx_data, tx_data_valid, done
  );

  modport slave (
    output start, address, data_in,
    input  ready, tx_address, tx_addr_valid, tx_data, tx_data_valid, done
  );
endinterface

// File: rtl/p2s_addr_data_tx.sv
// Parallel-to-serial transmitter: address LSB-first on tx_address, then data LSB-first on tx_data.
// Define P2S_PARITY_EN to append one even-parity bit on tx_data after the data bits.
module p2s_addr_data_tx #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rstn,
  p2s_addr_data_tx_if.master bus
);

`ifdef P2S_PARITY_EN
  typedef enum logic [2:0] {IDLE, ADDR, DATA, PARITY, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE} state_t;
`endif

  localparam logic [4:0] ADDR_LAST = 5'(ADDR_WIDTH - 1);
  localparam logic [4:0] DATA_LAST = 5'(DATA_WIDTH - 1);

  state_t                state;
  logic [4:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr_sr;
  logic [DATA_WIDTH-1:0] data_sr;
`ifdef P2S_PARITY_EN
  logic                  parity;
`endif

  // Outputs are loaded one edge ahead, so the state names the bit currently on the line.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state             <= IDLE;
      cnt               <= '0;
      addr_sr           <= '0;
      data_sr           <= '0;
`ifdef P2S_PARITY_EN
      parity            <= 1'b0;
`endif
      bus.ready         <= 1'b1;
      bus.tx_address    <= 1'b0;
      bus.tx_addr_valid <= 1'b0;
      bus.tx_data       <= 1'b0;
      bus.tx_data_valid <= 1'b0;
      bus.done          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            addr_sr           <= bus.address >> 1;
            data_sr           <= bus.data_in;
`ifdef P2S_PARITY_EN
            parity            <= ^bus.data_in;
`endif
            cnt               <= '0;
            bus.ready         <= 1'b0;
            bus.tx_address    <= bus.address[0];
            bus.tx_addr_valid <= 1'b1;
            state             <= ADDR;
          end
        end

        ADDR: begin
          if (cnt == ADDR_LAST) begin
            cnt               <= '0;
            bus.tx_address    <= 1'b0;
            bus.tx_addr_valid <= 1'b0;
            bus.tx_data       <= data_sr[0];
            bus.tx_data_valid <= 1'b1;
            data_sr           <= data_sr >> 1;
            state             <= DATA;
          end else begin
            cnt               <= cnt + 5'd1;
            bus.tx_address    <= addr_sr[0];
            addr_sr           <= addr_sr >> 1;
          end
        end

        DATA: begin
          if (cnt == DATA_LAST) begin
            cnt               <= '0;
`ifdef P2S_PARITY_EN
            bus.tx_data       <= parity;
            state             <= PARITY;
`else
            bus.tx_data       <= 1'b0;
            bus.tx_data_valid <= 1'b0;
            bus.done          <= 1'b1;
            state             <= DONE;
`endif
          end else begin
            cnt               <= cnt + 5'd1;
            bus.tx_data       <= data_sr[0];
            data_sr           <= data_sr >> 1;
          end
        end

`ifdef P2S_PARITY_EN
        PARITY: begin
          cnt               <= '0;
          bus.tx_data       <= 1'b0;
          bus.tx_data_valid <= 1'b0;
          bus.done          <= 1'b1;
          state             <= DONE;
        end
`endif

        DONE: begin
          bus.done  <= 1'b0;
          bus.ready <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
